// File: rtl/pipe_byte_packer.sv
// pipe_byte_packer
//   Packs the valid low bytes of each PIPE data word into a dense stream of full
//   DATA_BYTES-wide words. A flush drains any residual partial word, marked with a
//   byte keep mask and a last flag.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   in_vld/in_ready   input word handshake (in_data, in_mask)
//   in_mask           per-byte valid, expected contiguous from bit 0
//   flush             one-cycle pulse: drain residual bytes
//   out_valid/ready   output word handshake (out_data, out_keep, out_last)
//   flush_done        one-cycle pulse after a drain (or an empty flush) completes
//   mask_err          sticky: a non-contiguous in_mask was accepted
//   err_cnt           saturating count of non-contiguous masks
//
// Configuration
//   PIPE_BYTE_PACKER_ERR_CNT_EN  defined: err_cnt counts; undefined: err_cnt tied to 0.

module pipe_byte_packer #(
    parameter int unsigned DATA_BYTES = 64,
    parameter int unsigned BUF_BYTES  = 128,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic [DATA_BYTES*8-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_mask,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_BYTES*8-1:0] out_data,
    output logic [DATA_BYTES-1:0]   out_keep,
    output logic                    out_last,
    output logic                    flush_done,
    output logic                    mask_err,
    output logic [15:0]             err_cnt
);

    localparam int unsigned DW = DATA_BYTES * 8;
    localparam int unsigned BW = BUF_BYTES * 8;
    localparam logic [CNT_W-1:0] DataCnt = CNT_W'(DATA_BYTES);
    localparam logic [CNT_W-1:0] One = CNT_W'(1);
    localparam logic [DATA_BYTES-1:0] AllOnes = {DATA_BYTES{1'b1}};
    localparam logic [DATA_BYTES-1:0] MaskOne = DATA_BYTES'(1);

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic            out_valid_q, out_valid_d;
    logic [DATA_BYTES-1:0] out_keep_q, out_keep_d;
    logic            out_last_q, out_last_d;
    logic            in_ready_q, in_ready_d;
    logic            flush_done_q, flush_done_d;
    logic            mask_err_q;

    logic                  accept, pop, noncontig, run;
    logic [CNT_W-1:0]      nbytes, base, cnt_run;
    logic [DATA_BYTES-1:0] lane_ok;
    logic [DW-1:0]         in_bytes;
    logic [BW-1:0]         shifted, appended;

    assign accept = in_vld & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // A contiguous mask plus one has no bits in common with itself.
    assign noncontig = |(in_mask & (in_mask + MaskOne));

    // Trailing-ones count; lanes above the first zero are dropped.
    always_comb begin
        nbytes  = '0;
        lane_ok = '0;
        run     = 1'b1;
        for (int i = 0; i < DATA_BYTES; i++) begin
            run        = run & in_mask[i];
            lane_ok[i] = run;
            if (run) begin
                nbytes = nbytes + One;
            end
        end
    end

    always_comb begin
        in_bytes = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            in_bytes[8*i+:8] = lane_ok[i] ? in_data[8*i+:8] : 8'h00;
        end
    end

    // Bytes at or above cnt are always zero, so appending is a plain OR.
    assign shifted  = pop ? (buf_q >> DW) : buf_q;
    assign base     = pop ? (cnt_q - DataCnt) : cnt_q;
    assign appended = BW'(in_bytes) << {base, 3'b000};
    assign cnt_run  = base + (accept ? nbytes : '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        flush_done_d = 1'b0;
        case (state_q)
            StRun: begin
                buf_d = shifted | (accept ? appended : '0);
                cnt_d = cnt_run;
                if (flush) begin
                    if (cnt_run != '0) begin
                        state_d = StDrain;
                    end else begin
                        flush_done_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (pop) begin
                    if (out_last_q) begin
                        buf_d        = '0;
                        cnt_d        = '0;
                        state_d      = StRun;
                        flush_done_d = 1'b1;
                    end else begin
                        buf_d = shifted;
                        cnt_d = base;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Output flags are computed from next state so they come straight from flops.
    always_comb begin
        if (state_d == StRun) begin
            out_valid_d = (cnt_d >= DataCnt);
            out_keep_d  = out_valid_d ? AllOnes : '0;
            out_last_d  = 1'b0;
            in_ready_d  = (cnt_d <= DataCnt);
        end else begin
            out_valid_d = (cnt_d != '0);
            // Shifting by cnt >= DATA_BYTES yields zero, i.e. a full keep.
            out_keep_d  = out_valid_d ? ~(AllOnes << cnt_d) : '0;
            out_last_d  = out_valid_d && (cnt_d <= DataCnt);
            in_ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            buf_q        <= '0;
            out_valid_q  <= 1'b0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            flush_done_q <= 1'b0;
            mask_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            out_valid_q  <= out_valid_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            in_ready_q   <= in_ready_d;
            flush_done_q <= flush_done_d;
            if (accept && noncontig) begin
                mask_err_q <= 1'b1;
            end
        end
    end

`ifdef PIPE_BYTE_PACKER_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (accept && noncontig && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = buf_q[DW-1:0];
    assign out_keep   = out_keep_q;
    assign out_last   = out_last_q;
    assign flush_done = flush_done_q;
    assign mask_err   = mask_err_q;

endmodule

// File: tb/tb_pipe_byte_packer.sv
module tb_pipe_byte_packer;

    localparam logic [63:0] Gen1 = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] Gen2 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] Gen3 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld;
    logic [511:0] in_data;
    logic [63:0]  in_mask;
    logic         in_ready;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic [63:0]  out_keep;
    logic         out_last;
    logic         flush_done;
    logic         mask_err;
    logic [15:0]  err_cnt;

    int checks = 0;
    int failures = 0;

    pipe_byte_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_data    (in_data),
        .in_mask    (in_mask),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .flush_done (flush_done),
        .mask_err   (mask_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Buffer overflow would be a design bug.
    always @(negedge clk) begin
        assert (dut.cnt_q <= 8'd128)
        else $error("FAIL cnt_overflow cnt=%0d limit=128", dut.cnt_q);
    end

    function automatic logic [511:0] make_data(input logic [7:0] base);
        logic [511:0] d;
        for (int i = 0; i < 64; i++) d[8*i+:8] = base + 8'(i);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_vld = 1'b0; in_data = '0; in_mask = '0; flush = 1'b0; out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 512'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", out_data); end
        checks++; if (out_keep !== 64'd0) begin failures++; $display("FAIL reset_keep got=%0h exp=0", out_keep); end
        checks++; if ({out_last, flush_done, mask_err} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%0b exp=000", {out_last, flush_done, mask_err}); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (dut.cnt_q !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", dut.cnt_q); end
    endtask

    task automatic test_gen1();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_vld = 1'b1; in_mask = Gen1; in_data = make_data(8'(16 * k));
            tick();
        end
        in_vld = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gen1_valid got=%0b exp=1", out_valid); end
        checks++; if (out_data !== make_data(8'h00)) begin
            failures++; $display("FAIL gen1_data got=%0h exp=%0h", out_data, make_data(8'h00)); end
        checks++; if (out_keep !== Gen3 || out_last !== 1'b0) begin
            failures++; $display("FAIL gen1_keep_last got=%0h/%0b exp=%0h/0", out_keep, out_last, Gen3); end
        tick();
        checks++; if (out_valid !== 1'b0 || dut.cnt_q !== 8'd0) begin
            failures++; $display("FAIL gen1_drained got=%0b/%0d exp=0/0", out_valid, dut.cnt_q); end
    endtask

    task automatic test_gen3_stream();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_vld = 1'b1; in_mask = Gen3; in_data = make_data(8'(64 * k + 3));
            tick();
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                failures++; $display("FAIL gen3_hs k=%0d got=%0b/%0b exp=1/1", k, in_ready, out_valid); end
            checks++; if (out_data !== make_data(8'(64 * k + 3))) begin
                failures++; $display("FAIL gen3_data k=%0d got=%0h exp=%0h", k, out_data,
                                     make_data(8'(64 * k + 3))); end
        end
        in_vld = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || dut.cnt_q !== 8'd0) begin
            failures++; $display("FAIL gen3_end got=%0b/%0d exp=0/0", out_valid, dut.cnt_q); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_vld = 1'b1; in_mask = Gen3; in_data = make_data(8'h10);
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0b exp=1", in_ready); end
        in_data = make_data(8'h50);
        tick();
        checks++; if (in_ready !== 1'b0 || dut.cnt_q !== 8'd128) begin
            failures++; $display("FAIL bp_full got=%0b/%0d exp=0/128", in_ready, dut.cnt_q); end
        in_data = make_data(8'h90);
        tick();
        checks++; if (out_data !== make_data(8'h10) || in_ready !== 1'b0 || dut.cnt_q !== 8'd128) begin
            failures++; $display("FAIL bp_hold got=%0h/%0b/%0d exp=%0h/0/128", out_data, in_ready,
                                 dut.cnt_q, make_data(8'h10)); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== make_data(8'h50) || dut.cnt_q !== 8'd64 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_resume1 got=%0h/%0d/%0b exp=%0h/64/1", out_data, dut.cnt_q,
                                 in_ready, make_data(8'h50)); end
        tick();
        checks++; if (out_data !== make_data(8'h90) || dut.cnt_q !== 8'd64) begin
            failures++; $display("FAIL bp_resume2 got=%0h/%0d exp=%0h/64", out_data, dut.cnt_q,
                                 make_data(8'h90)); end
        in_vld = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || dut.cnt_q !== 8'd0) begin
            failures++; $display("FAIL bp_end got=%0b/%0d exp=0/0", out_valid, dut.cnt_q); end
    endtask

    task automatic test_flush_gen2();
        logic [511:0] exp;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_vld = 1'b1; in_mask = Gen2; in_data = make_data(8'(32 * k));
            tick();
        end
        in_vld = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (dut.state_q !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_enter got=%0b/%0b exp=1/0", dut.state_q, in_ready); end
        checks++; if (out_valid !== 1'b1 || out_keep !== Gen3 || out_last !== 1'b0) begin
            failures++; $display("FAIL flush_full got=%0b/%0h/%0b exp=1/%0h/0", out_valid, out_keep,
                                 out_last, Gen3); end
        checks++; if (out_data !== make_data(8'h00)) begin
            failures++; $display("FAIL flush_full_data got=%0h exp=%0h", out_data, make_data(8'h00)); end
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        exp = make_data(8'h40);
        exp[511:256] = '0;
        checks++; if (out_valid !== 1'b1 || out_keep !== Gen2 || out_last !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_part got=%0b/%0h/%0b/%0b exp=1/%0h/1/0", out_valid,
                                 out_keep, out_last, in_ready, Gen2); end
        checks++; if (out_data !== exp) begin
            failures++; $display("FAIL flush_part_data got=%0h exp=%0h", out_data, exp); end
        tick();
        checks++; if (flush_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || dut.cnt_q !== 8'd0) begin
            failures++; $display("FAIL flush_done got=%0b/%0b/%0b/%0d exp=1/0/1/0", flush_done,
                                 out_valid, in_ready, dut.cnt_q); end
        tick();
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL flush_done_pulse got=%0b exp=0", flush_done); end
    endtask

    task automatic test_mask_err();
        logic [511:0] exp;
        out_ready = 1'b0;
        in_vld = 1'b1; in_mask = 64'h0000_0000_0000_0F0F; in_data = make_data(8'h80);
        tick();
        in_vld = 1'b0; in_mask = '0;
        checks++; if (mask_err !== 1'b1 || dut.cnt_q !== 8'd4) begin
            failures++; $display("FAIL merr_flag got=%0b/%0d exp=1/4", mask_err, dut.cnt_q); end
`ifdef PIPE_BYTE_PACKER_ERR_CNT_EN
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL merr_cnt got=%0d exp=1", err_cnt); end
`else
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL merr_cnt got=%0d exp=0", err_cnt); end
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp = '0;
        exp[31:0] = 32'h8382_8180;
        checks++; if (out_keep !== 64'hF || out_last !== 1'b1 || out_data !== exp) begin
            failures++; $display("FAIL merr_word got=%0h/%0b/%0h exp=f/1/%0h", out_keep, out_last,
                                 out_data, exp); end
        out_ready = 1'b1;
        tick();
        checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL merr_done got=%0b exp=1", flush_done); end
        in_vld = 1'b1; in_mask = '0; in_data = make_data(8'hAA);
        tick();
        in_vld = 1'b0;
        checks++; if (dut.cnt_q !== 8'd0 || out_valid !== 1'b0 || mask_err !== 1'b1) begin
            failures++; $display("FAIL zero_mask got=%0d/%0b/%0b exp=0/0/1", dut.cnt_q, out_valid,
                                 mask_err); end
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b0;
        in_vld = 1'b1; in_mask = 64'h0000_00FF_FFFF_FFFF; in_data = make_data(8'h20);
        tick();
        in_vld = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1 || dut.cnt_q !== 8'd40 || out_keep !== 64'h0000_00FF_FFFF_FFFF) begin
            failures++; $display("FAIL rdrain_pre got=%0b/%0d/%0h exp=1/40/ffffffffff", out_valid,
                                 dut.cnt_q, out_keep); end
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || dut.cnt_q !== 8'd0 || dut.state_q !== 1'b0) begin
            failures++; $display("FAIL rdrain_async got=%0b/%0d/%0b exp=0/0/0", out_valid, dut.cnt_q,
                                 dut.state_q); end
        checks++; if (out_keep !== 64'd0 || out_data !== 512'd0 || mask_err !== 1'b0) begin
            failures++; $display("FAIL rdrain_clear got=%0h/%0h/%0b exp=0/0/0", out_keep, out_data,
                                 mask_err); end
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rdrain_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_flush_empty();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (flush_done !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL empty_flush got=%0b/%0b exp=1/0", flush_done, out_valid); end
        tick();
        checks++; if (flush_done !== 1'b0 || out_valid !== 1'b0 || dut.state_q !== 1'b0) begin
            failures++; $display("FAIL empty_after got=%0b/%0b/%0b exp=0/0/0", flush_done, out_valid,
                                 dut.state_q); end
    endtask

    initial begin
        test_reset();
        test_gen1();
        test_gen3_stream();
        test_backpressure();
        test_flush_gen2();
        test_mask_err();
        test_reset_mid_drain();
        test_flush_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
